// File: rtl/reset_pulse_seq.sv
// Staggered reset-release pulse sequencer: NUM_CH active-high pulses, channel i high for
// PULSE_CYCLES + i*STAGGER cycles. Define RSTSEQ_RETRIGGER_EN to let soft_rst_req restart a running sequence.
module reset_pulse_seq #(
  parameter int NUM_CH       = 3,
  parameter int PULSE_CYCLES = 2,
  parameter int STAGGER      = 1
) (
  input  logic              clk,
  input  logic              irstn,
  input  logic              soft_rst_req,
  output logic [NUM_CH-1:0] oreset,
  output logic              busy,
  output logic              done
);

  localparam int LMAX = PULSE_CYCLES + (NUM_CH - 1) * STAGGER;
  localparam int CW   = $clog2(LMAX + 1);
  localparam logic [CW-1:0] LMAX_C = CW'(LMAX);

  if (NUM_CH < 1 || PULSE_CYCLES < 1) begin : g_bad_param
    $error("reset_pulse_seq: NUM_CH and PULSE_CYCLES must both be >= 1");
  end

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_PULSE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NUM_CH-1:0] oreset_q, oreset_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              start;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    oreset_d = oreset_q;
    busy_d   = busy_q;
    done_d   = done_q;
    start    = 1'b0;
    unique case (state_q)
      ST_RST: start = 1'b1;
      ST_PULSE: begin
`ifdef RSTSEQ_RETRIGGER_EN
        start = soft_rst_req;
`else
        start = 1'b0;
`endif
        if (!start) begin
          // cnt is held at LMAX on the final edge so it can never wrap in DONE
          if (cnt_q == LMAX_C) begin
            state_d  = ST_DONE;
            oreset_d = '0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
            for (int i = 0; i < NUM_CH; i++) begin
              oreset_d[i] = (cnt_q < CW'(PULSE_CYCLES + i * STAGGER));
            end
          end
        end
      end
      ST_DONE: start = soft_rst_req;
      default: state_d = ST_RST;
    endcase
    if (start) begin
      state_d  = ST_PULSE;
      cnt_d    = CW'(1);
      oreset_d = '1;
      busy_d   = 1'b1;
      done_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!irstn) begin
      state_q  <= ST_RST;
      cnt_q    <= '0;
      oreset_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      oreset_q <= oreset_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign oreset = oreset_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_reset_pulse_seq.sv
// Directed bench for reset_pulse_seq (NUM_CH=3, PULSE_CYCLES=2, STAGGER=1 -> L = 2,3,4).
// Each check compares {oreset, busy, done} against a hand-computed value.
module tb_reset_pulse_seq;

  logic       clk = 1'b0;
  logic       irstn;
  logic       soft_rst_req;
  logic [2:0] oreset;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  reset_pulse_seq #(
    .NUM_CH(3),
    .PULSE_CYCLES(2),
    .STAGGER(1)
  ) dut (
    .clk(clk),
    .irstn(irstn),
    .soft_rst_req(soft_rst_req),
    .oreset(oreset),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  // Expected encodings: {oreset[2:0], busy, done}
  localparam logic [4:0] IDLE = 5'b000_0_0;
  localparam logic [4:0] ALL  = 5'b111_1_0;
  localparam logic [4:0] CH0  = 5'b110_1_0;
  localparam logic [4:0] CH1  = 5'b100_1_0;
  localparam logic [4:0] FIN  = 5'b000_0_1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {oreset, busy, done};
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    irstn        = 1'b0;
    soft_rst_req = 1'b0;

    // Held in reset: everything low
    tick(); chk("rst_hold0", IDLE);
    tick(); chk("rst_hold1", IDLE);
    tick(); chk("rst_hold2", IDLE);

    // Release: staggered drop at E2/E3/E4
    irstn = 1'b1;
    tick(); chk("seq_E0", ALL);
    tick(); chk("seq_E1", ALL);
    tick(); chk("seq_E2", CH0);
    tick(); chk("seq_E3", CH1);
    tick(); chk("seq_E4", FIN);
    tick(); chk("done_hold", FIN);

    // Soft request from DONE replays the same sequence
    soft_rst_req = 1'b1;
    tick(); chk("soft_E0", ALL);
    soft_rst_req = 1'b0;
    tick(); chk("soft_E1", ALL);
    tick(); chk("soft_E2", CH0);
    tick(); chk("soft_E3", CH1);
    tick(); chk("soft_E4", FIN);

    // Soft request during PULSE at E1
    soft_rst_req = 1'b1;
    tick(); chk("rtg_E0", ALL);
    tick(); chk("rtg_E1", ALL);
    soft_rst_req = 1'b0;
`ifdef RSTSEQ_RETRIGGER_EN
    tick(); chk("rtg_E2", ALL);
    tick(); chk("rtg_E3", CH0);
    tick(); chk("rtg_E4", CH1);
    tick(); chk("rtg_E5", FIN);
`else
    tick(); chk("rtg_E2", CH0);
    tick(); chk("rtg_E3", CH1);
    tick(); chk("rtg_E4", FIN);
    tick(); chk("rtg_E5", FIN);
`endif

    // irstn low mid-PULSE, then release restarts a full sequence
    soft_rst_req = 1'b1;
    tick(); chk("mid_E0", ALL);
    soft_rst_req = 1'b0;
    tick(); chk("mid_E1", ALL);
    irstn = 1'b0;
    tick(); chk("mid_E2", IDLE);
    tick(); chk("mid_E3", IDLE);
    irstn = 1'b1;
    tick(); chk("mid_E4", ALL);
    tick(); chk("mid_E5", ALL);
    tick(); chk("mid_E6", CH0);
    tick(); chk("mid_E7", CH1);
    tick(); chk("mid_E8", FIN);

    // Reset beats a simultaneous soft request
    soft_rst_req = 1'b1;
    irstn        = 1'b0;
    tick(); chk("rst_wins", IDLE);
    soft_rst_req = 1'b0;
    irstn        = 1'b1;
    tick(); chk("after_rst_E0", ALL);
    tick(); chk("after_rst_E1", ALL);
    tick(); chk("after_rst_E2", CH0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
